// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch controller and its watchdog.
package fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StWaitBr,
    StHalted,
    StFault
  } fetch_state_t;

  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam logic [7:0]  PC_LAST     = 8'hFF;

endpackage

// File: rtl/fetch_wdog.sv
// Stall watchdog: counts enabled cycles and flags expiry once the count reaches TIMEOUT.
module fetch_wdog
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [3:0] Limit = 4'(TIMEOUT);

  logic [3:0] cnt_q, cnt_d;

  // Saturates at Limit so a lingering enable can never wrap back to a non-expired value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC and instruction memory handshake, tracks retired
// instructions and active cycles, and aborts on stalls or PC wrap-around.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             imem_ack,
  input  logic             is_halt,
  input  logic             is_branch,
  input  logic             br_resolved,
  input  logic [7:0]       pc,
  output logic             imem_req,
  output logic             pc_hold,
  output logic             pc_clear,
  output logic             ir_load,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  fetch_state_t state_q, state_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  logic wd_en, wd_clr, wd_expired;
  logic cnt_clr, instr_inc, cycle_inc;

  fetch_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    pc_hold   = 1'b1;
    pc_clear  = 1'b0;
    ir_load   = 1'b0;
    wd_en     = 1'b0;
    cnt_clr   = 1'b0;
    instr_inc = 1'b0;
    cycle_inc = 1'b0;

    case (state_q)
      StIdle, StHalted, StFault: begin
        // Counters zero on entry so they already read 0 during CLEAR.
        if (start) begin
          state_d = StClear;
          cnt_clr = 1'b1;
        end
      end
      StClear: begin
        pc_clear = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = StFetch;
      end
      StFetch: begin
        imem_req  = 1'b1;
        ir_load   = imem_ack;
        cycle_inc = 1'b1;
        if (wd_expired) begin
          state_d = StFault;
        end else if (imem_ack) begin
          if (is_halt) begin
            instr_inc = 1'b1;
            state_d   = StHalted;
          end else if (pc == PC_LAST) begin
            state_d = StFault;
          end else if (is_branch) begin
            instr_inc = 1'b1;
            state_d   = StWaitBr;
          end else begin
            instr_inc = 1'b1;
            pc_hold   = 1'b0;
          end
        end else begin
          wd_en = 1'b1;
        end
      end
      StWaitBr: begin
        cycle_inc = 1'b1;
        if (wd_expired) begin
          state_d = StFault;
        end else if (br_resolved) begin
          pc_hold = 1'b0;
          state_d = StFetch;
        end else begin
          wd_en = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // The watchdog only accumulates across consecutive stalled cycles.
    wd_clr = ~wd_en;
  end

  always_comb begin
    instr_d = instr_q;
    cycle_d = cycle_q;
    if (cnt_clr) begin
      instr_d = '0;
      cycle_d = '0;
    end else begin
      if (instr_inc && (instr_q != '1)) instr_d = instr_q + CNT_W'(1);
      if (cycle_inc && (cycle_q != '1)) cycle_d = cycle_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cycle_q <= cycle_d;
    end
  end

  assign done        = (state_q == StHalted);
  assign fault       = (state_q == StFault);
  assign instr_count = instr_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random traffic,
// all compared against a mode/counter reference model kept here.
module tb_fetch_ctrl;

  localparam int TO = 15;

  localparam int MIdle   = 0;
  localparam int MClear  = 1;
  localparam int MFetch  = 2;
  localparam int MWait   = 3;
  localparam int MHalted = 4;
  localparam int MFault  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, imem_ack, is_halt, is_branch, br_resolved;
  logic [7:0]  pc;
  logic        imem_req, pc_hold, pc_clear, ir_load, done, fault;
  logic [15:0] instr_count, cycle_count;

  int errors = 0;
  int checks = 0;

  int m_mode, m_wd, m_ic, m_cc;
  bit e_req, e_hold, e_clr, e_ir, e_done, e_fault;
  logic [7:0] br_target;
  int hold_lows;

  fetch_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_ack    (imem_ack),
    .is_halt     (is_halt),
    .is_branch   (is_branch),
    .br_resolved (br_resolved),
    .pc          (pc),
    .imem_req    (imem_req),
    .pc_hold     (pc_hold),
    .pc_clear    (pc_clear),
    .ir_load     (ir_load),
    .done        (done),
    .fault       (fault),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic void model_reset();
    m_mode = MIdle;
    m_wd   = 0;
    m_ic   = 0;
    m_cc   = 0;
  endfunction

  // Expected outputs from the current model mode and the inputs presently driven.
  function automatic void predict();
    bit expired;
    expired = (m_wd >= TO);
    e_req   = (m_mode == MFetch);
    e_ir    = (m_mode == MFetch) && imem_ack;
    e_clr   = (m_mode == MClear);
    e_done  = (m_mode == MHalted);
    e_fault = (m_mode == MFault);
    e_hold  = 1'b1;
    if (m_mode == MFetch && !expired && imem_ack && !is_halt && !is_branch && pc != 8'hFF)
      e_hold = 1'b0;
    if (m_mode == MWait && !expired && br_resolved)
      e_hold = 1'b0;
  endfunction

  task automatic check_outs(input string ph);
    predict();
    chk({ph, ".imem_req"},    {31'd0, imem_req}, {31'd0, e_req});
    chk({ph, ".pc_hold"},     {31'd0, pc_hold},  {31'd0, e_hold});
    chk({ph, ".pc_clear"},    {31'd0, pc_clear}, {31'd0, e_clr});
    chk({ph, ".ir_load"},     {31'd0, ir_load},  {31'd0, e_ir});
    chk({ph, ".done"},        {31'd0, done},     {31'd0, e_done});
    chk({ph, ".fault"},       {31'd0, fault},    {31'd0, e_fault});
    chk({ph, ".instr_count"}, {16'd0, instr_count}, m_ic);
    chk({ph, ".cycle_count"}, {16'd0, cycle_count}, m_cc);
    if (pc_hold === 1'b0) hold_lows++;
  endtask

  // Model update for one clock edge, plus the external PC the bench emulates.
  task automatic advance();
    bit expired;
    int prev;
    predict();
    expired = (m_wd >= TO);
    prev    = m_mode;
    case (m_mode)
      MIdle, MHalted, MFault: begin
        m_wd = 0;
        if (start) begin
          m_mode = MClear;
          m_ic   = 0;
          m_cc   = 0;
        end
      end
      MClear: begin
        m_wd   = 0;
        m_mode = MFetch;
      end
      MFetch: begin
        m_cc = sat_inc(m_cc);
        if (expired) begin
          m_mode = MFault;
          m_wd   = 0;
        end else if (imem_ack) begin
          m_wd = 0;
          if (is_halt) begin
            m_ic   = sat_inc(m_ic);
            m_mode = MHalted;
          end else if (pc == 8'hFF) begin
            m_mode = MFault;
          end else begin
            m_ic = sat_inc(m_ic);
            if (is_branch) m_mode = MWait;
          end
        end else begin
          m_wd++;
        end
      end
      MWait: begin
        m_cc = sat_inc(m_cc);
        if (expired) begin
          m_mode = MFault;
          m_wd   = 0;
        end else if (br_resolved) begin
          m_wd   = 0;
          m_mode = MFetch;
        end else begin
          m_wd++;
        end
      end
      default: m_mode = MIdle;
    endcase
    if (e_clr) pc = 8'h00;
    else if (!e_hold) pc = (prev == MWait) ? br_target : pc + 8'd1;
  endtask

  task automatic cyc(input string ph, input bit st, input bit ack, input bit h, input bit b,
                     input bit r);
    start       = st;
    imem_ack    = ack;
    is_halt     = h;
    is_branch   = b;
    br_resolved = r;
    #3;
    check_outs(ph);
    @(posedge clk);
    #1;
    advance();
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; imem_ack = 1'b0; is_halt = 1'b0; is_branch = 1'b0; br_resolved = 1'b0;
    pc = 8'h00;
    br_target = 8'h10;
    hold_lows = 0;
    model_reset();
    #2;
    check_outs("reset");
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // No transition without start after release.
    cyc("idle0", 0, 1, 0, 0, 1);
    cyc("idle1", 0, 0, 0, 0, 0);

    // Three plain instructions then a halt at pc=3.
    cyc("s42_start", 1, 0, 0, 0, 0);
    cyc("s42_clear", 0, 0, 0, 0, 0);
    hold_lows = 0;
    cyc("s42_i0", 0, 1, 0, 0, 0);
    cyc("s42_stall", 0, 0, 0, 0, 1);
    cyc("s42_i1", 0, 1, 0, 0, 0);
    cyc("s42_i2", 0, 1, 0, 0, 0);
    chk("s42_pc", {24'd0, pc}, 32'd3);
    cyc("s42_halt", 0, 1, 1, 0, 0);
    chk("s42_hold_lows", hold_lows, 32'd3);
    chk("s42_done", {31'd0, done}, 32'd1);
    chk("s42_icount", {16'd0, instr_count}, 32'd4);
    cyc("s42_halted", 0, 0, 0, 0, 0);

    // Branch at pc=2, resolved on the fourth WAIT_BR cycle.
    cyc("s43_start", 1, 0, 0, 0, 0);
    cyc("s43_clear", 0, 0, 0, 0, 0);
    cyc("s43_i0", 0, 1, 0, 0, 0);
    cyc("s43_i1", 0, 1, 0, 0, 0);
    cyc("s43_br", 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("s43_wait", 0, 1, 0, 0, 0);
      chk("s43_wait_req", {31'd0, imem_req}, 32'd0);
    end
    br_target = 8'h40;
    cyc("s43_res", 0, 0, 0, 0, 1);
    chk("s43_ccount", {16'd0, cycle_count}, 32'd7);
    chk("s43_pc", {24'd0, pc}, 32'h40);
    cyc("s43_fetch", 0, 0, 0, 0, 0);

    // Stall in FETCH until the watchdog aborts.
    cyc("s44_start", 1, 0, 0, 0, 0);
    cyc("s44_clear", 0, 0, 0, 0, 0);
    for (int i = 0; i < TO + 1; i++) cyc("s44_stall", 0, 0, 0, 0, 0);
    chk("s44_fault", {31'd0, fault}, 32'd1);
    chk("s44_req", {31'd0, imem_req}, 32'd0);
    cyc("s44_fault_hold", 0, 0, 0, 0, 0);
    cyc("s44_restart", 1, 0, 0, 0, 0);
    chk("s44_clr_icount", {16'd0, instr_count}, 32'd0);
    chk("s44_clr_ccount", {16'd0, cycle_count}, 32'd0);
    cyc("s44_clear", 0, 0, 0, 0, 0);

    // Non-halt ack at pc=FF aborts without retiring.
    cyc("s45_i0", 0, 1, 0, 0, 0);
    pc = 8'hFF;
    cyc("s45_wrap", 0, 1, 0, 0, 0);
    chk("s45_fault", {31'd0, fault}, 32'd1);
    chk("s45_icount", {16'd0, instr_count}, 32'd1);
    cyc("s45_hold", 0, 0, 0, 0, 0);

    // Reset mid-branch, then start ignored in FETCH, then halt+branch together.
    cyc("s46_start", 1, 0, 0, 0, 0);
    cyc("s46_clear", 0, 0, 0, 0, 0);
    cyc("s46_br", 0, 1, 0, 1, 0);
    cyc("s46_wait", 0, 0, 0, 0, 0);
    start = 1'b0; imem_ack = 1'b0; is_halt = 1'b0; is_branch = 1'b0; br_resolved = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    pc = 8'h00;
    check_outs("s46_rst");
    @(posedge clk);
    #1;
    check_outs("s46_rst_held");
    reset = 1'b1;
    cyc("s46_idle", 0, 0, 0, 0, 0);
    cyc("s46_start", 1, 0, 0, 0, 0);
    cyc("s46_clear", 0, 0, 0, 0, 0);
    cyc("s46_st_fetch", 1, 0, 0, 0, 0);
    cyc("s46_st_fetch2", 1, 1, 0, 0, 0);
    cyc("s46_hb", 0, 1, 1, 1, 0);
    chk("s46_done", {31'd0, done}, 32'd1);

    // Random traffic with periodic quiet stretches to exercise the watchdog.
    for (int i = 0; i < 800; i++) begin
      bit quiet;
      bit st, ack, h, b, r;
      quiet = ((i / 40) % 3) == 2;
      st  = ($urandom_range(7, 0) == 0);
      ack = !quiet && ($urandom_range(1, 0) == 1);
      h   = ($urandom_range(15, 0) == 0);
      b   = ($urandom_range(5, 0) == 0);
      r   = !quiet && ($urandom_range(2, 0) == 0);
      br_target = ($urandom_range(3, 0) == 0) ? 8'hF8 + 8'($urandom_range(7, 0))
                                             : 8'($urandom_range(255, 0));
      cyc("rand", st, ack, h, b, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, the maximum cycles to wait for imem_ack or br_resolved before faulting (range 1..15).
REQ-002 Parameter CNT_W, default 16, the width of the performance counters.
REQ-003 clk  in  1  the single system clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  starts a program run from PC 0; sampled only in IDLE, HALTED and FAULT.
REQ-006 imem_ack  in  1  instruction word valid this cycle.
REQ-007 is_halt  in  1  the decoded instruction is a halt; qualified by imem_ack.
REQ-008 is_branch  in  1  the decoded instruction is a branch; qualified by imem_ack.
REQ-009 br_resolved  in  1  execute has resolved the outstanding branch.
REQ-010 pc  in  8  the current fetch-unit PC value.
REQ-011 imem_req  out  1  instruction fetch request.
REQ-012 pc_hold  out  1  drives the PC halt input.
REQ-013 pc_clear  out  1  drives the PC synchronous reset input.
REQ-014 ir_load  out  1  captures the instruction register.
REQ-015 done  out  1  the program halted normally.
REQ-016 fault  out  1  the program aborted.
REQ-017 instr_count  out  CNT_W  the number of retired instructions.
REQ-018 cycle_count  out  CNT_W  the number of active cycles.

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, FETCH, WAIT_BR, HALTED and FAULT.
REQ-020 IDLE: imem_req=0, pc_hold=1; start=1 -> CLEAR.
REQ-021 CLEAR: pc_clear=1 and pc_hold=1 for exactly 1 cycle; both counters and the watchdog zeroed; next state FETCH unconditionally.
REQ-022 FETCH: imem_req=1; pc_hold=1 until imem_ack=1; ir_load=imem_ack, combinational, same cycle.
REQ-023 FETCH, ack, plain instruction (is_halt=0, is_branch=0, pc!=8'hFF): pc_hold=0 for that cycle only, so the PC advances by 1; instr_count+1; stay in FETCH with the watchdog cleared.
REQ-024 FETCH, ack with is_halt=1: pc_hold stays 1; instr_count+1; -> HALTED; is_halt takes priority over is_branch.
REQ-025 FETCH, ack with is_branch=1 (is_halt=0): pc_hold stays 1; instr_count+1; -> WAIT_BR with the watchdog cleared.
REQ-026 WAIT_BR: imem_req=0; on br_resolved=1, pc_hold=0 for that cycle only, so the PC applies its branch/advance; -> FETCH.
REQ-027 FETCH, ack, non-halt instruction with pc==8'hFF (wrap-around): pc_hold stays 1; the instruction is not counted; -> FAULT.
REQ-028 The watchdog SHALL count cycles in FETCH without ack and in WAIT_BR without br_resolved; when it reaches TIMEOUT -> FAULT on the next edge.
REQ-029 HALTED: done=1, pc_hold=1, imem_req=0; start -> CLEAR.
REQ-030 FAULT: fault=1, pc_hold=1, imem_req=0; start -> CLEAR.
REQ-031 start asserted in CLEAR, FETCH or WAIT_BR SHALL be ignored.
REQ-032 br_resolved outside WAIT_BR, and imem_ack outside FETCH, SHALL be ignored.
REQ-033 cycle_count SHALL increment on every cycle spent in FETCH or WAIT_BR.
REQ-034 Both counters SHALL saturate at all-ones and hold their values in IDLE, HALTED and FAULT until the next CLEAR.
REQ-035 done and fault SHALL be Moore outputs (decoded from state only); imem_req, pc_clear, pc_hold and ir_load SHALL be decoded from state plus the current inputs.

Reset
REQ-036 While reset=0, the FSM SHALL immediately enter IDLE, regardless of state, including mid-fetch and mid-branch.
REQ-037 Reset values: imem_req=0, pc_hold=1, pc_clear=0, ir_load=0, done=0, fault=0, instr_count=0, cycle_count=0, watchdog=0.
REQ-038 After reset release, no transition SHALL occur until start=1 is sampled in IDLE.

Structure
REQ-039 Shared package fetch_pkg SHALL hold: the state enum fetch_state_t, TIMEOUT_DEF=15, CNT_W_DEF=16 and PC_LAST=8'hFF.
REQ-040 The watchdog SHALL be one sub-module, fetch_wdog: a 4-bit counter with clr/en inputs and an expired output at TIMEOUT.
REQ-041 The counters and FSM SHALL reside in fetch_ctrl; there SHALL be no other sub-modules.

Verification
REQ-042 Reset, start, then acks for 3 plain instructions and a halt at pc=3 -> the pc_clear pulse occurs 1 cycle after start; pc_hold=0 on exactly 3 ack cycles; done=1; instr_count=4.
REQ-043 A branch acked at pc=2 with br_resolved 4 cycles later -> WAIT_BR for 4 cycles with imem_req=0; one pc_hold=0 cycle; FETCH resumes; cycle_count includes the 4 cycles.
REQ-044 In FETCH with no ack for 15 cycles -> fault=1 and imem_req=0; a later start -> CLEAR and counters=0.
REQ-045 Non-halt ack at pc=8'hFF -> FAULT; pc_hold stays 1; instr_count unchanged.
REQ-046 reset driven low mid-WAIT_BR -> IDLE with all REQ-037 values at once; start ignored while in FETCH; is_halt=is_branch=1 on ack -> HALTED.
